bus_phase_seq: RTL and testbench
================================

Name: bus_phase_seq

Overview:
- Upstream strobe generator for the GSTMCU latch stages.
- Divides the system clock into fixed-length bus cycles and arbitrates each cycle between video and CPU.
- Drives one-clock gate and reset pulses into the address and data latch cells; generates CPU dtack.
- Sits between the CPU bus interface and the latch-based address/data holding registers.

Parameters:
- PHASES, 8, clocks per bus cycle; power of two, 4..16.
- ADDR_GATE_PH, 1, phase at which addr_g pulses in a CPU-owned cycle.
- DATA_GATE_PH, 5, phase at which data_g pulses in a CPU-owned cycle; must satisfy ADDR_GATE_PH < DATA_GATE_PH < PHASES-1.

Ports:
- clock, in, 1, system clock.
- reset, in, 1, synchronous, active-high reset.
- en, in, 1, phase-advance enable; the counter moves only when en=1.
- cpu_as, in, 1, CPU access request (level, active-high), held until dtack is seen.
- video_req, in, 1, video wants the next even cycle; sampled at phase 0.
- phase, out, $clog2(PHASES), current phase count.
- video_slot, out, 1, current cycle is owned by video.
- cpu_slot, out, 1, current cycle is owned by CPU.
- addr_g, out, 1, one-clock gate pulse to the address latch.
- data_g, out, 1, one-clock gate pulse to the data latch.
- data_r, out, 1, one-clock reset pulse to the data latch at the start of a CPU cycle.
- dtack, out, 1, CPU transfer acknowledge.
- busy, out, 1, FSM not IDLE.

Behaviour:
- Reset (synchronous, active-high): phase=0, parity=0, FSM=IDLE; all outputs 0. Reset asserted mid-operation aborts the access the next edge; no dtack is produced for it.
- Counter:
  - On en=1, phase increments; PHASES-1 wraps to 0.
  - The parity bit toggles on each wrap.
  - en=0 freezes phase and all FSM state; pulse outputs are 0 while en=0.
- Slot decision, registered on the edge where phase becomes 0:
  - parity=0 and video_req=1: video_slot=1, cpu_slot=0.
  - Otherwise: cpu_slot=1, video_slot=0.
  - Both flags hold for the whole cycle.
- CPU FSM states: IDLE, WAIT, ADDR, DATA, ACK.
  - IDLE -> WAIT when cpu_as=1.
  - WAIT -> ADDR when a CPU-owned cycle begins (phase enters 0 with cpu_slot being set). A request raised mid-cycle waits for the next cycle start.
  - ADDR: data_r=1 for the first clock at phase 0; addr_g=1 for one clock when phase enters ADDR_GATE_PH; then -> DATA.
  - DATA: data_g=1 for one clock when phase enters DATA_GATE_PH; then -> ACK at phase PHASES-1.
  - ACK: dtack=1 from entering phase PHASES-1 until cpu_as=0; then dtack=0 and -> IDLE on that edge.
  - cpu_as dropped in WAIT, ADDR or DATA: -> IDLE next edge; no further pulses; dtack stays 0.
  - cpu_as re-asserted in the same clock it left ACK: enters WAIT on the following edge. Minimum one IDLE clock.
- Simultaneous events:
  - video_req and cpu_as both high at an even-cycle start: video wins; CPU waits for the next (odd) cycle.
  - Video never preempts an in-progress CPU cycle.
- All outputs are registered; no combinational path from inputs to outputs.
- Pulse widths are exactly one clock regardless of en duty. A pulse fires only on the edge where phase changes to the named value.

Optional Feature:
- BUS_PHASE_STRICT_EN defined: even cycles belong to video unconditionally. The CPU is granted odd cycles only, even when video_req=0 (real-ST-exact alternation).
- BUS_PHASE_STRICT_EN undefined: an even cycle with video_req=0 is given to the CPU, as described under Behaviour.

Decomposition:
- Shared package bus_phase_pkg:
  - FSM state enum (IDLE, WAIT, ADDR, DATA, ACK).
  - Default PHASES / ADDR_GATE_PH / DATA_GATE_PH constants.
  - Phase-width function.
- One natural sub-module, bus_phase_cnt: the counter, parity bit and phase-entry one-shot generator (outputs "entered phase N" strobes).
- FSM and slot logic stay in bus_phase_seq.

Test Plan:
- Reset and counting: reset held 3 clocks, en=1 constant -> phase=0 and outputs 0 during reset; phase counts 0..7, wraps; parity toggles every 8 clocks.
- Basic CPU access (video_req=0): cpu_as=1 at phase 3 -> data_r at next phase 0, addr_g at phase 1, data_g at phase 5, dtack at phase 7. Drop cpu_as 2 clocks later -> dtack=0 next edge, busy=0.
- Video contention (video_req=1 at even-cycle start, cpu_as=1) -> video_slot=1 for 8 clocks, no gate pulses; CPU sequence runs in the following odd cycle.
- Abort: cpu_as drops at phase 3 of a CPU cycle -> no data_g, no dtack, FSM IDLE next edge. Reset at phase 4 of a CPU cycle -> all outputs 0 next edge.
- en gating (en=1 one clock in four) -> phase advances once per 4 clocks; each gate pulse is still exactly one clock wide.
- With BUS_PHASE_STRICT_EN, video_req=0, cpu_as=1 at an even-cycle start -> CPU waits 8 clocks and starts at the odd cycle. Without the macro -> CPU starts immediately.

Source files
------------

// File: rtl/bus_phase_pkg.sv
// bus_phase_pkg: shared definitions for the bus phase sequencer.
//   - seq_state_t : CPU access FSM states
//   - DEF_*       : default bus-cycle length and gate phases
//   - phase_w()   : width of the phase counter for a given cycle length
package bus_phase_pkg;

  localparam int unsigned DEF_PHASES       = 8;
  localparam int unsigned DEF_ADDR_GATE_PH = 1;
  localparam int unsigned DEF_DATA_GATE_PH = 5;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ADDR,
    DATA,
    ACK
  } seq_state_t;

  function automatic int unsigned phase_w(input int unsigned phases);
    return (phases > 1) ? $clog2(phases) : 1;
  endfunction

endpackage

// File: rtl/bus_phase_cnt.sv
// bus_phase_cnt: bus-cycle phase counter with cycle parity and phase-entry strobes.
// Ports:
//   clock, reset (sync, active-high), en (advance enable)
//   phase        : current phase, wraps PHASES-1 -> 0
//   parity       : toggles on every wrap (0 = even cycle)
//   enter_first  : the coming edge moves phase to 0
//   enter_addr   : the coming edge moves phase to ADDR_GATE_PH
//   enter_data   : the coming edge moves phase to DATA_GATE_PH
//   enter_last   : the coming edge moves phase to PHASES-1
// The strobes are combinational look-aheads; a consumer that registers a pulse
// on a strobe gets a one-clock pulse aligned with the first clock of that phase.
module bus_phase_cnt
  import bus_phase_pkg::*;
#(
  parameter int unsigned PHASES       = DEF_PHASES,
  parameter int unsigned ADDR_GATE_PH = DEF_ADDR_GATE_PH,
  parameter int unsigned DATA_GATE_PH = DEF_DATA_GATE_PH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         en,
  output logic [phase_w(PHASES)-1:0]   phase,
  output logic                         parity,
  output logic                         enter_first,
  output logic                         enter_addr,
  output logic                         enter_data,
  output logic                         enter_last
);

  localparam int unsigned   PW   = phase_w(PHASES);
  localparam logic [PW-1:0] LAST = PW'(PHASES - 1);

  logic [PW-1:0] phase_nxt;

  always_comb begin
    phase_nxt = (phase == LAST) ? '0 : phase + PW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase  <= '0;
      parity <= 1'b0;
    end else if (en) begin
      phase <= phase_nxt;
      if (phase == LAST) begin
        parity <= ~parity;
      end
    end
  end

  assign enter_first = en && (phase_nxt == '0);
  assign enter_addr  = en && (phase_nxt == PW'(ADDR_GATE_PH));
  assign enter_data  = en && (phase_nxt == PW'(DATA_GATE_PH));
  assign enter_last  = en && (phase_nxt == LAST);

endmodule

// File: rtl/bus_phase_seq.sv
// bus_phase_seq: bus-cycle sequencer arbitrating each cycle between video and CPU
// and strobing the address/data latch cells.
// Ports:
//   clock, reset (sync, active-high), en (phase-advance enable)
//   cpu_as     : CPU request level, held until dtack
//   video_req  : video wants the next even cycle (sampled as phase enters 0)
//   phase      : current phase count
//   video_slot / cpu_slot : owner of the current cycle
//   addr_g, data_g : one-clock gate pulses to the address / data latches
//   data_r     : one-clock reset pulse to the data latch at CPU cycle start
//   dtack      : CPU transfer acknowledge
//   busy       : access FSM not idle
// Build option: BUS_PHASE_STRICT_EN gives every even cycle to video regardless of
// video_req; by default an even cycle without video_req goes to the CPU.
module bus_phase_seq
  import bus_phase_pkg::*;
#(
  parameter int unsigned PHASES       = DEF_PHASES,
  parameter int unsigned ADDR_GATE_PH = DEF_ADDR_GATE_PH,
  parameter int unsigned DATA_GATE_PH = DEF_DATA_GATE_PH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       cpu_as,
  input  logic                       video_req,
  output logic [phase_w(PHASES)-1:0] phase,
  output logic                       video_slot,
  output logic                       cpu_slot,
  output logic                       addr_g,
  output logic                       data_g,
  output logic                       data_r,
  output logic                       dtack,
  output logic                       busy
);

  logic       parity;
  logic       enter_first;
  logic       enter_addr;
  logic       enter_data;
  logic       enter_last;
  logic       video_win;
  seq_state_t state;

  bus_phase_cnt #(
    .PHASES       (PHASES),
    .ADDR_GATE_PH (ADDR_GATE_PH),
    .DATA_GATE_PH (DATA_GATE_PH)
  ) u_cnt (
    .clock       (clock),
    .reset       (reset),
    .en          (en),
    .phase       (phase),
    .parity      (parity),
    .enter_first (enter_first),
    .enter_addr  (enter_addr),
    .enter_data  (enter_data),
    .enter_last  (enter_last)
  );

  // parity is still the old cycle's value at the wrap edge, so parity=1 means
  // the cycle about to begin is even.
`ifdef BUS_PHASE_STRICT_EN
  logic strict_unused;
  assign strict_unused = video_req;
  assign video_win     = parity;
`else
  assign video_win     = parity && video_req;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      video_slot <= 1'b0;
      cpu_slot   <= 1'b0;
      addr_g     <= 1'b0;
      data_g     <= 1'b0;
      data_r     <= 1'b0;
      dtack      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      addr_g <= 1'b0;
      data_g <= 1'b0;
      data_r <= 1'b0;

      if (enter_first) begin
        video_slot <= video_win;
        cpu_slot   <= !video_win;
      end

      if (en) begin
        case (state)
          IDLE: begin
            if (cpu_as) begin
              state <= WAIT;
              busy  <= 1'b1;
            end
          end
          WAIT: begin
            if (!cpu_as) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else if (enter_first && !video_win) begin
              state  <= ADDR;
              data_r <= 1'b1;
            end
          end
          ADDR: begin
            if (!cpu_as) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else if (enter_addr) begin
              state  <= DATA;
              addr_g <= 1'b1;
            end
          end
          DATA: begin
            if (!cpu_as) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              if (enter_data) begin
                data_g <= 1'b1;
              end
              if (enter_last) begin
                state <= ACK;
                dtack <= 1'b1;
              end
            end
          end
          ACK: begin
            if (!cpu_as) begin
              state <= IDLE;
              busy  <= 1'b0;
              dtack <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
            dtack <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bus_phase_seq.sv
module tb_bus_phase_seq;

  localparam int P  = 8;
  localparam int AP = 1;
  localparam int DP = 5;

  logic       clock;
  logic       reset;
  logic       en;
  logic       cpu_as;
  logic       video_req;
  logic [2:0] phase;
  logic       video_slot;
  logic       cpu_slot;
  logic       addr_g;
  logic       data_g;
  logic       data_r;
  logic       dtack;
  logic       busy;

  int total;
  int bad;

  // Reference model: cnt counts enabled edges since reset, so phase and cycle
  // index follow by division; the access is tracked as pending / owning / acking.
  int cnt;
  bit m_vid, m_cpu, m_pend, m_own, m_ack, m_ag, m_dg, m_dr;

  bus_phase_seq #(
    .PHASES       (P),
    .ADDR_GATE_PH (AP),
    .DATA_GATE_PH (DP)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .en         (en),
    .cpu_as     (cpu_as),
    .video_req  (video_req),
    .phase      (phase),
    .video_slot (video_slot),
    .cpu_slot   (cpu_slot),
    .addr_g     (addr_g),
    .data_g     (data_g),
    .data_r     (data_r),
    .dtack      (dtack),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [9:0] obs();
    return {phase, video_slot, cpu_slot, addr_g, data_g, data_r, dtack, busy};
  endfunction

  function automatic logic [9:0] expv();
    return {3'(cnt % P), m_vid, m_cpu, m_ag, m_dg, m_dr, m_ack, m_pend | m_own | m_ack};
  endfunction

  task automatic model_edge();
    int np;
    bit start;
    bit even;
    m_ag = 0;
    m_dg = 0;
    m_dr = 0;
    if (reset) begin
      cnt = 0;
      m_vid = 0; m_cpu = 0; m_pend = 0; m_own = 0; m_ack = 0;
    end else if (en) begin
      cnt++;
      np    = cnt % P;
      start = (np == 0);
      even  = ((cnt / P) % 2) == 0;
      if (start) begin
`ifdef BUS_PHASE_STRICT_EN
        m_vid = even;
`else
        m_vid = even && video_req;
`endif
        m_cpu = !m_vid;
      end
      if (!cpu_as) begin
        m_pend = 0; m_own = 0; m_ack = 0;
      end else if (m_pend) begin
        if (start && m_cpu) begin
          m_pend = 0; m_own = 1; m_dr = 1;
        end
      end else if (m_own) begin
        if (np == AP) m_ag = 1;
        if (np == DP) m_dg = 1;
        if (np == P - 1) begin
          m_own = 0; m_ack = 1;
        end
      end else if (!m_ack) begin
        m_pend = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1; en = 1; cpu_as = 0; video_req = 0;
    tick();
    reset = 0;
  endtask

  task automatic run_to(input int target);
    int guard;
    guard = 0;
    while (cnt < target && guard < 200) begin
      tick();
      guard++;
    end
  endtask

  task automatic test_reset();
    reset = 1; en = 1; cpu_as = 0; video_req = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (obs() !== 10'b0) begin
        bad++;
        $display("FAIL reset_hold[%0d]: got %b want %b", i, obs(), 10'b0);
      end
    end
    reset = 0;
    for (int i = 1; i <= 17; i++) begin
      tick();
      total++;
      if (phase !== 3'(i % P) || dut.u_cnt.parity !== 1'((i / P) % 2)) begin
        bad++;
        $display("FAIL count[%0d]: got phase=%0d parity=%b want phase=%0d parity=%0d",
                 i, phase, dut.u_cnt.parity, i % P, (i / P) % 2);
      end
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL count_outputs[%0d]: got %b want %b", i, obs(), expv());
      end
    end
  endtask

  task automatic test_basic_access();
    int n_dr, n_ag, n_dg, b;
    n_dr = 0; n_ag = 0; n_dg = 0;
    do_reset();
    run_to(3);
    cpu_as = 1;
    for (b = 0; b < 40 && dtack !== 1'b1; b++) begin
      tick();
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL basic_step cnt=%0d: got %b want %b", cnt, obs(), expv());
      end
      if (data_r === 1'b1) begin
        n_dr++; total++;
        if (phase !== 3'd0) begin bad++; $display("FAIL basic_data_r_phase: got %0d want 0", phase); end
      end
      if (addr_g === 1'b1) begin
        n_ag++; total++;
        if (phase !== 3'(AP)) begin bad++; $display("FAIL basic_addr_g_phase: got %0d want %0d", phase, AP); end
      end
      if (data_g === 1'b1) begin
        n_dg++; total++;
        if (phase !== 3'(DP)) begin bad++; $display("FAIL basic_data_g_phase: got %0d want %0d", phase, DP); end
      end
    end
    total++;
    if (dtack !== 1'b1 || phase !== 3'(P - 1) || cnt != 15) begin
      bad++;
      $display("FAIL basic_dtack: got dtack=%b phase=%0d cnt=%0d want dtack=1 phase=7 cnt=15", dtack, phase, cnt);
    end
    total++;
    if (n_dr != 1 || n_ag != 1 || n_dg != 1) begin
      bad++;
      $display("FAIL basic_pulse_count: got dr=%0d ag=%0d dg=%0d want 1 1 1", n_dr, n_ag, n_dg);
    end
    tick();
    tick();
    total++;
    if (dtack !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_dtack_hold: got dtack=%b busy=%b want 1 1", dtack, busy);
    end
    cpu_as = 0;
    tick();
    total++;
    if (dtack !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_release: got dtack=%b busy=%b want 0 0", dtack, busy);
    end
  endtask

  task automatic test_video_contention();
    int b, dr_cnt;
    dr_cnt = -1;
    do_reset();
    run_to(11);
    cpu_as = 1; video_req = 1;
    run_to(15);
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if (video_slot !== 1'b1 || cpu_slot !== 1'b0 || {addr_g, data_g, data_r, dtack} !== 4'b0 ||
          obs() !== expv()) begin
        bad++;
        $display("FAIL video_slot cnt=%0d: got %b want %b (video owned, no pulses)", cnt, obs(), expv());
      end
    end
    for (b = 0; b < 12 && dtack !== 1'b1; b++) begin
      tick();
      if (data_r === 1'b1) dr_cnt = cnt;
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL video_cpu_follow cnt=%0d: got %b want %b", cnt, obs(), expv());
      end
    end
    total++;
    if (dr_cnt != 24 || dtack !== 1'b1) begin
      bad++;
      $display("FAIL video_cpu_start: got data_r at cnt=%0d dtack=%b want cnt=24 dtack=1", dr_cnt, dtack);
    end
    cpu_as = 0; video_req = 0;
    tick();
  endtask

  task automatic test_abort();
    do_reset();
    run_to(3);
    cpu_as = 1;
    run_to(11);
    cpu_as = 0;
    tick();
    total++;
    if (busy !== 1'b0 || obs() !== expv()) begin
      bad++;
      $display("FAIL abort_idle: got busy=%b out=%b want busy=0 out=%b", busy, obs(), expv());
    end
    while (cnt < 17) begin
      tick();
      total++;
      if (data_g !== 1'b0 || dtack !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL abort_quiet cnt=%0d: got data_g=%b dtack=%b busy=%b want 0 0 0", cnt, data_g, dtack, busy);
      end
    end
    do_reset();
    cpu_as = 1;
    run_to(12);
    reset = 1;
    tick();
    total++;
    if (obs() !== 10'b0) begin
      bad++;
      $display("FAIL reset_abort: got %b want %b", obs(), 10'b0);
    end
    reset = 0; cpu_as = 0;
    tick();
  endtask

  task automatic test_en_gating();
    int adv, n_ag, n_dg, n_dr;
    logic [2:0] prev_ph;
    logic [2:0] prev_pulse;
    adv = 0; n_ag = 0; n_dg = 0; n_dr = 0;
    prev_pulse = '0;
    do_reset();
    cpu_as = 1;
    for (int k = 0; k < 96; k++) begin
      en = (k % 4 == 3);
      prev_ph = phase;
      tick();
      if (phase !== prev_ph) adv++;
      n_ag += int'(addr_g === 1'b1);
      n_dg += int'(data_g === 1'b1);
      n_dr += int'(data_r === 1'b1);
      total++;
      if (obs() !== expv() || (prev_pulse & {addr_g, data_g, data_r}) !== 3'b0) begin
        bad++;
        $display("FAIL en_gate_step k=%0d: got %b want %b prev_pulse=%b", k, obs(), expv(), prev_pulse);
      end
      prev_pulse = {addr_g, data_g, data_r};
    end
    en = 1;
    total++;
    if (adv != 24) begin
      bad++;
      $display("FAIL en_gate_advance: got %0d advances want 24", adv);
    end
    total++;
    if (n_ag != 1 || n_dg != 1 || n_dr != 1 || dtack !== 1'b1) begin
      bad++;
      $display("FAIL en_gate_pulses: got ag=%0d dg=%0d dr=%0d dtack=%b want 1 1 1 1", n_ag, n_dg, n_dr, dtack);
    end
    cpu_as = 0;
    tick();
  endtask

  task automatic test_strict();
    int b, dr_cnt, want;
    dr_cnt = -1;
`ifdef BUS_PHASE_STRICT_EN
    want = 24;
`else
    want = 16;
`endif
    do_reset();
    run_to(9);
    cpu_as = 1; video_req = 0;
    for (b = 0; b < 30 && dr_cnt < 0; b++) begin
      tick();
      if (data_r === 1'b1) dr_cnt = cnt;
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL strict_step cnt=%0d: got %b want %b", cnt, obs(), expv());
      end
    end
    total++;
    if (dr_cnt != want) begin
      bad++;
      $display("FAIL strict_grant: got data_r at cnt=%0d want cnt=%0d", dr_cnt, want);
    end
    cpu_as = 0;
    tick();
  endtask

  task automatic test_back_to_back();
    int b;
    do_reset();
    cpu_as = 1;
    for (b = 0; b < 40 && dtack !== 1'b1; b++) tick();
    cpu_as = 0;
    tick();
    cpu_as = 1;
    total++;
    if (busy !== 1'b0 || dtack !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle_gap: got busy=%b dtack=%b want 0 0", busy, dtack);
    end
    tick();
    total++;
    if (busy !== 1'b1 || obs() !== expv()) begin
      bad++;
      $display("FAIL b2b_rewait: got busy=%b out=%b want busy=1 out=%b", busy, obs(), expv());
    end
    for (b = 0; b < 40 && dtack !== 1'b1; b++) begin
      tick();
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL b2b_step cnt=%0d: got %b want %b", cnt, obs(), expv());
      end
    end
    total++;
    if (dtack !== 1'b1) begin
      bad++;
      $display("FAIL b2b_second_dtack: got %b want 1", dtack);
    end
    cpu_as = 0;
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      en        = ($urandom_range(0, 3) != 0);
      video_req = 1'($urandom_range(0, 1));
      if (dtack === 1'b1 && $urandom_range(0, 2) == 0) cpu_as = 0;
      else if ($urandom_range(0, 15) == 0) cpu_as = ~cpu_as;
      tick();
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL random[%0d]: got %b want %b", i, obs(), expv());
      end
    end
    reset = 0; en = 1; cpu_as = 0; video_req = 0;
  endtask

  initial begin
    total = 0; bad = 0;
    cnt = 0;
    m_vid = 0; m_cpu = 0; m_pend = 0; m_own = 0; m_ack = 0;
    m_ag = 0; m_dg = 0; m_dr = 0;
    reset = 1; en = 1; cpu_as = 0; video_req = 0;
    test_reset();
    test_basic_access();
    test_video_contention();
    test_abort();
    test_en_gating();
    test_strict();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
